// File: rtl/sc_casas_registro_pkg.sv
// Shared constants and the state encoding for the Frogger home-row occupancy block.
// The level width is also used by the score and display blocks.
package sc_casas_registro_pkg;

  localparam int DEFAULT_NUM_CASAS = 8;
  localparam int LEVEL_W           = 4;
  localparam int COUNT_W           = 4;
  localparam int COL_W             = 3;

  typedef enum logic [0:0] {
    ST_PLAY      = 1'b0,
    ST_FULL_HOLD = 1'b1
  } casas_state_t;

endpackage

// File: rtl/sc_casas_registro_if.sv
// Arrival/clear requests from the game logic and the occupancy status returned to it.
interface sc_casas_registro_if
  import sc_casas_registro_pkg::*;
#(
  parameter int NUM_CASAS = DEFAULT_NUM_CASAS
);

  logic                 SC_CASAS_arrive_valid_In;
  logic [COL_W-1:0]     SC_CASAS_arrive_col_In;
  logic                 SC_CASAS_clear_req_In;
  logic [NUM_CASAS-1:0] SC_CASAS_casas_Out;
  logic                 SC_CASAS_arrive_ok_Out;
  logic                 SC_CASAS_arrive_reject_Out;
  logic                 SC_CASAS_level_done_Out;
  logic                 SC_CASAS_busy_Out;
  logic [COUNT_W-1:0]   SC_CASAS_count_Out;
  logic [LEVEL_W-1:0]   SC_CASAS_level_Out;

  modport master (
    output SC_CASAS_arrive_valid_In, SC_CASAS_arrive_col_In, SC_CASAS_clear_req_In,
    input  SC_CASAS_casas_Out, SC_CASAS_arrive_ok_Out, SC_CASAS_arrive_reject_Out,
    input  SC_CASAS_level_done_Out, SC_CASAS_busy_Out, SC_CASAS_count_Out, SC_CASAS_level_Out
  );

  modport slave (
    input  SC_CASAS_arrive_valid_In, SC_CASAS_arrive_col_In, SC_CASAS_clear_req_In,
    output SC_CASAS_casas_Out, SC_CASAS_arrive_ok_Out, SC_CASAS_arrive_reject_Out,
    output SC_CASAS_level_done_Out, SC_CASAS_busy_Out, SC_CASAS_count_Out, SC_CASAS_level_Out
  );

endinterface

// File: rtl/sc_casas_hold_timer.sv
// Up-counter timing the full-row celebration; flags the last cycle of the hold.
module sc_casas_hold_timer #(
  parameter  int HOLD_CYCLES = 50_000_000,
  localparam int WIDTH       = $clog2(HOLD_CYCLES + 1)
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_terminal
);

  localparam logic [WIDTH-1:0] TERM_COUNT = WIDTH'(HOLD_CYCLES - 1);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign o_terminal = (r_count == TERM_COUNT);

endmodule

// File: rtl/sc_casas_registro.sv
// Home-row occupancy owner: accepts/rejects frog arrivals, holds a full row for
// HOLD_CYCLES, then clears it and advances the saturating level counter.
module sc_casas_registro
  import sc_casas_registro_pkg::*;
#(
  parameter int NUM_CASAS   = DEFAULT_NUM_CASAS,
  parameter int HOLD_CYCLES = 50_000_000
) (
  input  logic                SC_CASAS_CLOCK_50,
  input  logic                SC_CASAS_RESET_InLow,
  sc_casas_registro_if.slave  casas_bus
);

  casas_state_t         r_state;
  logic [NUM_CASAS-1:0] r_casas;
  logic [COUNT_W-1:0]   r_count;
  logic [LEVEL_W-1:0]   r_level;
  logic                 r_ok;
  logic                 r_reject;
  logic                 r_level_done;
  logic                 r_busy;

  logic [7:0]           w_col_onehot;
  logic [NUM_CASAS-1:0] w_col_mask;
  logic                 w_col_in_range;
  logic                 w_col_taken;
  logic                 w_hold_term;
  logic                 w_timer_clear;
  logic                 w_timer_enable;

  assign w_col_onehot   = 8'd1 << casas_bus.SC_CASAS_arrive_col_In;
  assign w_col_mask     = w_col_onehot[NUM_CASAS-1:0];
  assign w_col_in_range = ({1'b0, casas_bus.SC_CASAS_arrive_col_In} < 4'(NUM_CASAS));
  assign w_col_taken    = |(w_col_mask & r_casas);

  // Timer idles at zero outside the hold, so entering FULL_HOLD always starts from 0.
  assign w_timer_enable = (r_state == ST_FULL_HOLD);
  assign w_timer_clear  = (r_state != ST_FULL_HOLD) || casas_bus.SC_CASAS_clear_req_In || w_hold_term;

  sc_casas_hold_timer #(
    .HOLD_CYCLES (HOLD_CYCLES)
  ) u_hold_timer (
    .i_clk      (SC_CASAS_CLOCK_50),
    .i_rst_n    (SC_CASAS_RESET_InLow),
    .i_clear    (w_timer_clear),
    .i_enable   (w_timer_enable),
    .o_terminal (w_hold_term)
  );

  always_ff @(posedge SC_CASAS_CLOCK_50) begin
    if (!SC_CASAS_RESET_InLow) begin
      r_state      <= ST_PLAY;
      r_casas      <= '0;
      r_count      <= '0;
      r_level      <= '0;
      r_ok         <= 1'b0;
      r_reject     <= 1'b0;
      r_level_done <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_ok         <= 1'b0;
      r_reject     <= 1'b0;
      r_level_done <= 1'b0;
      // A new-game request wins over everything, including a same-cycle arrival.
      if (casas_bus.SC_CASAS_clear_req_In) begin
        r_state <= ST_PLAY;
        r_casas <= '0;
        r_count <= '0;
        r_level <= '0;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          ST_PLAY: begin
            if (casas_bus.SC_CASAS_arrive_valid_In) begin
              if (w_col_in_range && !w_col_taken) begin
                r_casas <= r_casas | w_col_mask;
                r_count <= r_count + 4'd1;
                r_ok    <= 1'b1;
                if (r_count == 4'(NUM_CASAS - 1)) begin
                  r_state <= ST_FULL_HOLD;
                  r_busy  <= 1'b1;
                end
              end else begin
                r_reject <= 1'b1;
              end
            end
          end
          ST_FULL_HOLD: begin
            if (w_hold_term) begin
              r_state      <= ST_PLAY;
              r_casas      <= '0;
              r_count      <= '0;
              r_busy       <= 1'b0;
              r_level_done <= 1'b1;
              if (r_level != {LEVEL_W{1'b1}}) begin
                r_level <= r_level + 4'd1;
              end
            end
          end
          default: begin
            r_state <= ST_PLAY;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign casas_bus.SC_CASAS_casas_Out         = r_casas;
  assign casas_bus.SC_CASAS_count_Out         = r_count;
  assign casas_bus.SC_CASAS_level_Out         = r_level;
  assign casas_bus.SC_CASAS_arrive_ok_Out     = r_ok;
  assign casas_bus.SC_CASAS_arrive_reject_Out = r_reject;
  assign casas_bus.SC_CASAS_level_done_Out    = r_level_done;
  assign casas_bus.SC_CASAS_busy_Out          = r_busy;

endmodule

// File: tb/tb_sc_casas_registro.sv
// Randomised and directed checks of sc_casas_registro against a cycle-level behavioural model.
module tb_sc_casas_registro;

  localparam int HOLD = 4;
  localparam int NUM  = 8;

  logic clk;
  logic rst_n;
  int   tests_run;
  int   tests_failed;

  // Behavioural model of the 8-home instance.
  bit [7:0] m_casas;
  int       m_level;
  int       m_elapsed;
  bit       m_busy;
  bit       m_ok;
  bit       m_rej;
  bit       m_done;

  sc_casas_registro_if #(.NUM_CASAS(8)) bus8 ();
  sc_casas_registro_if #(.NUM_CASAS(5)) bus5 ();

  sc_casas_registro #(.NUM_CASAS(8), .HOLD_CYCLES(HOLD)) dut8 (
    .SC_CASAS_CLOCK_50    (clk),
    .SC_CASAS_RESET_InLow (rst_n),
    .casas_bus            (bus8.slave)
  );

  sc_casas_registro #(.NUM_CASAS(5), .HOLD_CYCLES(HOLD)) dut5 (
    .SC_CASAS_CLOCK_50    (clk),
    .SC_CASAS_RESET_InLow (rst_n),
    .casas_bus            (bus5.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [19:0] observed();
    return {bus8.SC_CASAS_casas_Out, bus8.SC_CASAS_arrive_ok_Out, bus8.SC_CASAS_arrive_reject_Out,
            bus8.SC_CASAS_level_done_Out, bus8.SC_CASAS_busy_Out, bus8.SC_CASAS_count_Out,
            bus8.SC_CASAS_level_Out};
  endfunction

  function automatic logic [19:0] expected();
    return {m_casas, m_ok, m_rej, m_done, m_busy, 4'($countones(m_casas)), 4'(m_level)};
  endfunction

  function automatic void model_step(bit rn, bit valid, bit [2:0] col, bit clear);
    m_ok   = 0;
    m_rej  = 0;
    m_done = 0;
    if (!rn) begin
      m_casas = 0; m_level = 0; m_elapsed = 0; m_busy = 0;
    end else if (clear) begin
      m_casas = 0; m_level = 0; m_elapsed = 0; m_busy = 0;
    end else if (m_busy) begin
      m_elapsed++;
      if (m_elapsed == HOLD) begin
        m_casas = 0;
        m_busy  = 0;
        m_done  = 1;
        m_level = (m_level < 15) ? m_level + 1 : 15;
      end
    end else if (valid) begin
      if (int'(col) < NUM && !m_casas[col]) begin
        m_casas[col] = 1'b1;
        m_ok = 1;
        if ($countones(m_casas) == NUM) begin
          m_busy    = 1;
          m_elapsed = 0;
        end
      end else begin
        m_rej = 1;
      end
    end
  endfunction

  // Apply one cycle of stimulus to the 8-home DUT and advance the model; sample 1 time unit after the edge.
  task automatic step(input bit rn, input bit valid, input bit [2:0] col, input bit clear);
    rst_n                         = rn;
    bus8.SC_CASAS_arrive_valid_In = valid;
    bus8.SC_CASAS_arrive_col_In   = col;
    bus8.SC_CASAS_clear_req_In    = clear;
    model_step(rn, valid, col, clear);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      step(0, 1, 3'd1, 0);
      tests_run++;
      if (observed() !== 20'h0) begin
        $display("FAIL reset: observed %h expected %h", observed(), 20'h0);
        tests_failed++;
      end
    end
  endtask

  task automatic test_basic_arrival();
    step(1, 1, 3'd3, 0);
    tests_run++;
    if (observed() !== expected() || bus8.SC_CASAS_casas_Out !== 8'h08 || bus8.SC_CASAS_arrive_ok_Out !== 1'b1) begin
      $display("FAIL first_arrival: observed %h expected %h", observed(), expected());
      tests_failed++;
    end
    step(1, 1, 3'd3, 0);
    tests_run++;
    if (observed() !== expected() || bus8.SC_CASAS_arrive_reject_Out !== 1'b1 || bus8.SC_CASAS_casas_Out !== 8'h08) begin
      $display("FAIL repeat_arrival: observed %h expected %h", observed(), expected());
      tests_failed++;
    end
    step(1, 0, 3'd0, 0);
    tests_run++;
    if (observed() !== expected()) begin
      $display("FAIL pulse_drop: observed %h expected %h", observed(), expected());
      tests_failed++;
    end
  endtask

  task automatic test_narrow_row();
    bus5.SC_CASAS_arrive_valid_In = 1'b1;
    bus5.SC_CASAS_arrive_col_In   = 3'd7;
    step(1, 0, 3'd0, 0);
    tests_run++;
    if (bus5.SC_CASAS_arrive_reject_Out !== 1'b1 || bus5.SC_CASAS_arrive_ok_Out !== 1'b0 || bus5.SC_CASAS_casas_Out !== 5'h00) begin
      $display("FAIL narrow_col7: rej=%b ok=%b casas=%h expected rej=1 ok=0 casas=00",
               bus5.SC_CASAS_arrive_reject_Out, bus5.SC_CASAS_arrive_ok_Out, bus5.SC_CASAS_casas_Out);
      tests_failed++;
    end
    bus5.SC_CASAS_arrive_col_In = 3'd4;
    step(1, 0, 3'd0, 0);
    tests_run++;
    if (bus5.SC_CASAS_arrive_ok_Out !== 1'b1 || bus5.SC_CASAS_casas_Out !== 5'h10 || bus5.SC_CASAS_count_Out !== 4'd1) begin
      $display("FAIL narrow_col4: ok=%b casas=%h count=%0d expected ok=1 casas=10 count=1",
               bus5.SC_CASAS_arrive_ok_Out, bus5.SC_CASAS_casas_Out, bus5.SC_CASAS_count_Out);
      tests_failed++;
    end
    bus5.SC_CASAS_arrive_col_In = 3'd5;
    step(1, 0, 3'd0, 0);
    tests_run++;
    if (bus5.SC_CASAS_arrive_reject_Out !== 1'b1 || bus5.SC_CASAS_casas_Out !== 5'h10) begin
      $display("FAIL narrow_col5: rej=%b casas=%h expected rej=1 casas=10",
               bus5.SC_CASAS_arrive_reject_Out, bus5.SC_CASAS_casas_Out);
      tests_failed++;
    end
    bus5.SC_CASAS_arrive_valid_In = 1'b0;
  endtask

  task automatic test_fill_and_hold();
    step(1, 0, 3'd0, 1);
    for (int c = 0; c < NUM; c++) begin
      step(1, 1, 3'(c), 0);
      tests_run++;
      if (observed() !== expected()) begin
        $display("FAIL fill_col%0d: observed %h expected %h", c, observed(), expected());
        tests_failed++;
      end
    end
    tests_run++;
    if (bus8.SC_CASAS_casas_Out !== 8'hFF || bus8.SC_CASAS_busy_Out !== 1'b1) begin
      $display("FAIL fill_full: casas=%h busy=%b expected casas=ff busy=1", bus8.SC_CASAS_casas_Out, bus8.SC_CASAS_busy_Out);
      tests_failed++;
    end
    for (int k = 1; k <= HOLD; k++) begin
      step(1, (k == 1), 3'd2, 0);
      tests_run++;
      if (observed() !== expected()) begin
        $display("FAIL hold_cycle%0d: observed %h expected %h", k, observed(), expected());
        tests_failed++;
      end
    end
    tests_run++;
    if (bus8.SC_CASAS_level_done_Out !== 1'b1 || bus8.SC_CASAS_casas_Out !== 8'h00 || bus8.SC_CASAS_level_Out !== 4'd1) begin
      $display("FAIL hold_end: done=%b casas=%h level=%0d expected done=1 casas=00 level=1",
               bus8.SC_CASAS_level_done_Out, bus8.SC_CASAS_casas_Out, bus8.SC_CASAS_level_Out);
      tests_failed++;
    end
  endtask

  task automatic test_clear_vs_arrival();
    step(1, 1, 3'd5, 0);
    step(1, 1, 3'd2, 1);
    tests_run++;
    if (observed() !== expected() || bus8.SC_CASAS_casas_Out !== 8'h00) begin
      $display("FAIL clear_with_arrival: observed %h expected %h", observed(), expected());
      tests_failed++;
    end
  endtask

  task automatic test_clear_mid_hold();
    for (int c = 0; c < NUM; c++) step(1, 1, 3'(7 - c), 0);
    step(1, 0, 3'd0, 0);
    step(1, 0, 3'd0, 1);
    tests_run++;
    if (observed() !== expected() || bus8.SC_CASAS_busy_Out !== 1'b0 || bus8.SC_CASAS_level_done_Out !== 1'b0) begin
      $display("FAIL clear_mid_hold: observed %h expected %h", observed(), expected());
      tests_failed++;
    end
    for (int k = 0; k < HOLD; k++) begin
      step(1, 0, 3'd0, 0);
      tests_run++;
      if (observed() !== expected()) begin
        $display("FAIL after_clear%0d: observed %h expected %h", k, observed(), expected());
        tests_failed++;
      end
    end
  endtask

  task automatic test_back_to_back_random();
    for (int i = 0; i < 400; i++) begin
      step(1, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), ($urandom_range(0, 39) == 0));
      tests_run++;
      if (observed() !== expected()) begin
        $display("FAIL random_cycle%0d: observed %h expected %h", i, observed(), expected());
        tests_failed++;
      end
    end
  endtask

  task automatic test_level_saturation();
    step(1, 0, 3'd0, 1);
    for (int lvl = 0; lvl < 17; lvl++) begin
      for (int k = 0; k < NUM + HOLD; k++) begin
        step(1, (k < NUM), 3'((lvl + k) % NUM), 0);
        tests_run++;
        if (observed() !== expected()) begin
          $display("FAIL level%0d_cycle%0d: observed %h expected %h", lvl, k, observed(), expected());
          tests_failed++;
        end
      end
    end
    tests_run++;
    if (bus8.SC_CASAS_level_Out !== 4'd15) begin
      $display("FAIL level_saturate: level=%0d expected 15", bus8.SC_CASAS_level_Out);
      tests_failed++;
    end
  endtask

  task automatic test_reset_mid_play();
    step(1, 1, 3'd1, 0);
    step(1, 1, 3'd6, 0);
    step(0, 1, 3'd4, 0);
    tests_run++;
    if (observed() !== 20'h0 || bus5.SC_CASAS_casas_Out !== 5'h00) begin
      $display("FAIL reset_mid_play: observed %h expected %h", observed(), 20'h0);
      tests_failed++;
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    m_casas = 0; m_level = 0; m_elapsed = 0; m_busy = 0;
    m_ok = 0; m_rej = 0; m_done = 0;
    rst_n = 1'b0;
    bus8.SC_CASAS_arrive_valid_In = 1'b0;
    bus8.SC_CASAS_arrive_col_In   = 3'd0;
    bus8.SC_CASAS_clear_req_In    = 1'b0;
    bus5.SC_CASAS_arrive_valid_In = 1'b0;
    bus5.SC_CASAS_arrive_col_In   = 3'd0;
    bus5.SC_CASAS_clear_req_In    = 1'b0;

    test_reset();
    test_basic_arrival();
    test_narrow_row();
    test_fill_and_hold();
    test_clear_vs_arrival();
    test_clear_mid_hold();
    test_back_to_back_random();
    test_level_saturation();
    test_reset_mid_play();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
